// File: rtl/fpu_int_responder_if.sv
// Signal bundle between the FPU exception handler / interrupt controller side
// and the interrupt responder.
interface fpu_int_responder_if;
  logic       int_request;
  logic [5:0] latched_exceptions;
  logic       irq_enable;
  logic       irq_ack;
  logic       clear_cmd;
  logic       exception_clear;
  logic       irq_out;
  logic [5:0] cause;
  logic       cause_valid;
  logic       stuck;
  logic [7:0] irq_count;
  logic [2:0] state_dbg;

  modport master (
    output int_request, latched_exceptions, irq_enable, irq_ack, clear_cmd,
    input  exception_clear, irq_out, cause, cause_valid, stuck, irq_count, state_dbg
  );

  modport slave (
    input  int_request, latched_exceptions, irq_enable, irq_ack, clear_cmd,
    output exception_clear, irq_out, cause, cause_valid, stuck, irq_count, state_dbg
  );
endinterface

// File: rtl/fpu_int_responder.sv
// Turns the FPU handler's level INT into an acknowledged IRQ, issues the clear
// pulse back to the handler and watches that INT actually drops afterwards.
module fpu_int_responder #(
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  fpu_int_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    SERVICE = 3'd2,
    CLEAR   = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] cause_q, cause_d;
  logic       cause_valid_q, cause_valid_d;
  logic       stuck_q, stuck_d;
  logic [7:0] count_q, count_d;
  logic [7:0] drain_q, drain_d;
  logic       clr_q, clr_d;
  logic       irq_q, irq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cause_q       <= 6'h00;
      cause_valid_q <= 1'b0;
      stuck_q       <= 1'b0;
      count_q       <= 8'h00;
      drain_q       <= 8'h00;
      clr_q         <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      cause_valid_q <= cause_valid_d;
      stuck_q       <= stuck_d;
      count_q       <= count_d;
      drain_q       <= drain_d;
      clr_q         <= clr_d;
      irq_q         <= irq_d;
    end
  end

  // The clear pulse is registered on the edge that enters CLEAR (or services a
  // stuck recovery), so it is high for exactly the following cycle.
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    cause_valid_d = cause_valid_q;
    stuck_d       = stuck_q;
    count_d       = count_q;
    drain_d       = drain_q;
    clr_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.int_request && bus.irq_enable && !stuck_q) begin
          cause_d       = bus.latched_exceptions;
          cause_valid_d = 1'b1;
          state_d       = PENDING;
        end else if (bus.clear_cmd && stuck_q) begin
          stuck_d = 1'b0;
          clr_d   = 1'b1;
        end
      end
      PENDING: begin
        if (bus.clear_cmd) begin
          state_d = CLEAR;
          clr_d   = 1'b1;
        end else if (bus.irq_ack) begin
          state_d = SERVICE;
        end else if (!bus.irq_enable) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.clear_cmd) begin
          state_d = CLEAR;
          clr_d   = 1'b1;
        end
      end
      CLEAR: begin
        cause_valid_d = 1'b0;
        count_d       = count_q + 8'd1;
        drain_d       = DRAIN_LOAD;
        state_d       = DRAIN;
      end
      DRAIN: begin
        if (!bus.int_request) begin
          state_d = IDLE;
        end else if (drain_q == 8'd0) begin
          stuck_d = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // IRQ rises one cycle after PENDING entry and falls on the edge that leaves it.
    irq_d = (state_q == PENDING) && (state_d == PENDING);
  end

  assign bus.exception_clear = clr_q;
  assign bus.irq_out         = irq_q;
  assign bus.cause           = cause_q;
  assign bus.cause_valid     = cause_valid_q;
  assign bus.stuck           = stuck_q;
  assign bus.irq_count       = count_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_fpu_int_responder.sv
// Directed bench for fpu_int_responder with a cause/count scoreboard.
module tb_fpu_int_responder;

  localparam int DT = 16;

  logic clk;
  logic reset_n;
  fpu_int_responder_if bus ();

  fpu_int_responder #(.DRAIN_TIMEOUT(DT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int expCount   = 0;
  logic [5:0] causeQ[$];
  logic [7:0] countQ[$];
  logic sawIrq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic waitIrq(input string tag);
    for (int i = 0; i < 4 && bus.irq_out !== 1'b1; i++) tick();
    checkOutput(tag, {31'd0, bus.irq_out}, 32'd1);
  endtask

  // Full acknowledged service of one interrupt, ending back in IDLE.
  task automatic applyStimulus(input logic [5:0] exc);
    bus.latched_exceptions = exc;
    bus.int_request = 1'b1;
    causeQ.push_back(exc);
    waitIrq("svc irq");
    checkOutput("svc cause", {26'd0, bus.cause}, {26'd0, causeQ.pop_front()});
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.clear_cmd = 1'b1;
    tick();
    bus.clear_cmd = 1'b0;
    bus.int_request = 1'b0;
    expCount = (expCount + 1) % 256;
    countQ.push_back(8'(expCount));
    tick();
    tick();
    checkOutput("svc count", {24'd0, bus.irq_count}, {24'd0, countQ.pop_front()});
  endtask

  initial begin
    reset_n = 1'b0;
    bus.int_request = 1'b0;
    bus.latched_exceptions = 6'h00;
    bus.irq_enable = 1'b0;
    bus.irq_ack = 1'b0;
    bus.clear_cmd = 1'b0;
    repeat (2) tick();
    checkOutput("rst state", {29'd0, bus.state_dbg}, 32'd0);
    checkOutput("rst irq", {31'd0, bus.irq_out}, 32'd0);
    checkOutput("rst clr", {31'd0, bus.exception_clear}, 32'd0);
    checkOutput("rst cause", {26'd0, bus.cause}, 32'd0);
    checkOutput("rst cvalid", {31'd0, bus.cause_valid}, 32'd0);
    checkOutput("rst stuck", {31'd0, bus.stuck}, 32'd0);
    checkOutput("rst count", {24'd0, bus.irq_count}, 32'd0);
    reset_n = 1'b1;

    // Basic acknowledged path
    bus.irq_enable = 1'b1;
    bus.latched_exceptions = 6'h01;
    bus.int_request = 1'b1;
    causeQ.push_back(6'h01);
    tick();
    checkOutput("basic irq +1", {31'd0, bus.irq_out}, 32'd0);
    checkOutput("basic state pend", {29'd0, bus.state_dbg}, 32'd1);
    checkOutput("basic cvalid", {31'd0, bus.cause_valid}, 32'd1);
    tick();
    checkOutput("basic irq +2", {31'd0, bus.irq_out}, 32'd1);
    checkOutput("basic cause", {26'd0, bus.cause}, {26'd0, causeQ.pop_front()});
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    checkOutput("basic irq after ack", {31'd0, bus.irq_out}, 32'd0);
    checkOutput("basic state svc", {29'd0, bus.state_dbg}, 32'd2);
    bus.clear_cmd = 1'b1;
    tick();
    bus.clear_cmd = 1'b0;
    expCount++;
    countQ.push_back(8'(expCount));
    checkOutput("basic clr pulse", {31'd0, bus.exception_clear}, 32'd1);
    checkOutput("basic state clear", {29'd0, bus.state_dbg}, 32'd3);
    tick();
    checkOutput("basic clr end", {31'd0, bus.exception_clear}, 32'd0);
    checkOutput("basic state drain", {29'd0, bus.state_dbg}, 32'd4);
    checkOutput("basic cvalid cleared", {31'd0, bus.cause_valid}, 32'd0);
    bus.int_request = 1'b0;
    tick();
    checkOutput("basic state idle", {29'd0, bus.state_dbg}, 32'd0);
    checkOutput("basic count", {24'd0, bus.irq_count}, {24'd0, countQ.pop_front()});
    checkOutput("basic cause held", {26'd0, bus.cause}, 32'h01);

    // Polled path, clear wins over a simultaneous ack
    bus.latched_exceptions = 6'h3F;
    bus.int_request = 1'b1;
    causeQ.push_back(6'h3F);
    tick();
    tick();
    checkOutput("poll irq", {31'd0, bus.irq_out}, 32'd1);
    checkOutput("poll cause", {26'd0, bus.cause}, {26'd0, causeQ.pop_front()});
    bus.clear_cmd = 1'b1;
    bus.irq_ack = 1'b1;
    tick();
    bus.clear_cmd = 1'b0;
    bus.irq_ack = 1'b0;
    expCount++;
    countQ.push_back(8'(expCount));
    checkOutput("poll state clear", {29'd0, bus.state_dbg}, 32'd3);
    checkOutput("poll clr pulse", {31'd0, bus.exception_clear}, 32'd1);
    checkOutput("poll irq low", {31'd0, bus.irq_out}, 32'd0);
    tick();
    checkOutput("poll cause kept", {26'd0, bus.cause}, 32'h3F);
    bus.int_request = 1'b0;
    tick();
    checkOutput("poll count", {24'd0, bus.irq_count}, {24'd0, countQ.pop_front()});

    // Disabled path and enable falling while pending
    bus.irq_enable = 1'b0;
    bus.latched_exceptions = 6'h12;
    bus.int_request = 1'b1;
    sawIrq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sawIrq = sawIrq | bus.irq_out;
    end
    checkOutput("dis no irq", {31'd0, sawIrq}, 32'd0);
    checkOutput("dis state idle", {29'd0, bus.state_dbg}, 32'd0);
    bus.irq_enable = 1'b1;
    causeQ.push_back(6'h12);
    tick();
    checkOutput("en irq +1", {31'd0, bus.irq_out}, 32'd0);
    tick();
    checkOutput("en irq +2", {31'd0, bus.irq_out}, 32'd1);
    checkOutput("en cause", {26'd0, bus.cause}, {26'd0, causeQ.pop_front()});
    bus.irq_enable = 1'b0;
    tick();
    checkOutput("dis pend state", {29'd0, bus.state_dbg}, 32'd0);
    checkOutput("dis pend irq", {31'd0, bus.irq_out}, 32'd0);
    checkOutput("dis pend cvalid", {31'd0, bus.cause_valid}, 32'd1);
    bus.irq_enable = 1'b1;
    causeQ.push_back(6'h12);
    tick();
    tick();
    checkOutput("reen irq", {31'd0, bus.irq_out}, 32'd1);
    checkOutput("reen cause", {26'd0, bus.cause}, {26'd0, causeQ.pop_front()});

    // Stuck handler: INT never drops after the clear pulse
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.clear_cmd = 1'b1;
    tick();
    bus.clear_cmd = 1'b0;
    expCount++;
    countQ.push_back(8'(expCount));
    tick();
    checkOutput("stuck drain entry", {29'd0, bus.state_dbg}, 32'd4);
    for (int i = 0; i < DT - 1; i++) tick();
    checkOutput("stuck not yet", {31'd0, bus.stuck}, 32'd0);
    checkOutput("stuck still drain", {29'd0, bus.state_dbg}, 32'd4);
    tick();
    checkOutput("stuck set", {31'd0, bus.stuck}, 32'd1);
    checkOutput("stuck state idle", {29'd0, bus.state_dbg}, 32'd0);
    sawIrq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sawIrq = sawIrq | bus.irq_out;
    end
    checkOutput("stuck no reraise", {31'd0, sawIrq}, 32'd0);
    checkOutput("stuck count", {24'd0, bus.irq_count}, {24'd0, countQ.pop_front()});
    bus.int_request = 1'b0;
    bus.clear_cmd = 1'b1;
    tick();
    bus.clear_cmd = 1'b0;
    checkOutput("unstick flag", {31'd0, bus.stuck}, 32'd0);
    checkOutput("unstick clr pulse", {31'd0, bus.exception_clear}, 32'd1);
    checkOutput("unstick count", {24'd0, bus.irq_count}, expCount);
    tick();
    checkOutput("unstick clr end", {31'd0, bus.exception_clear}, 32'd0);
    bus.clear_cmd = 1'b1;
    tick();
    bus.clear_cmd = 1'b0;
    checkOutput("idle clr ignored", {31'd0, bus.exception_clear}, 32'd0);

    // Asynchronous reset mid-PENDING, between clock edges
    bus.latched_exceptions = 6'h2A;
    bus.int_request = 1'b1;
    causeQ.push_back(6'h2A);
    tick();
    tick();
    checkOutput("arst pre irq", {31'd0, bus.irq_out}, 32'd1);
    checkOutput("arst pre cause", {26'd0, bus.cause}, {26'd0, causeQ.pop_front()});
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst irq", {31'd0, bus.irq_out}, 32'd0);
    checkOutput("arst state", {29'd0, bus.state_dbg}, 32'd0);
    checkOutput("arst cause", {26'd0, bus.cause}, 32'd0);
    checkOutput("arst cvalid", {31'd0, bus.cause_valid}, 32'd0);
    checkOutput("arst stuck", {31'd0, bus.stuck}, 32'd0);
    checkOutput("arst count", {24'd0, bus.irq_count}, 32'd0);
    checkOutput("arst clr", {31'd0, bus.exception_clear}, 32'd0);
    expCount = 0;
    bus.int_request = 1'b0;
    tick();
    reset_n = 1'b1;

    // First edge after reset release samples INT normally
    bus.latched_exceptions = 6'h04;
    bus.int_request = 1'b1;
    tick();
    checkOutput("post rst sample", {29'd0, bus.state_dbg}, 32'd1);
    bus.int_request = 1'b0;
    bus.irq_enable = 1'b0;
    tick();
    bus.irq_enable = 1'b1;

    // Counter wrap over 256 complete services
    for (int n = 0; n < 256; n++) begin
      applyStimulus(6'(n));
      if (n == 254) checkOutput("wrap at ff", {24'd0, bus.irq_count}, 32'hFF);
    end
    checkOutput("wrap to zero", {24'd0, bus.irq_count}, 32'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fpu_int_responder.md
FPU_INT_RESPONDER -- requirements
Module: fpu_int_responder

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 16: cycles to wait for int_request to fall after a clear (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port int_request, input, 1: level INT from the FPU exception handler.
REQ-005 SHALL have port latched_exceptions, input, 6: handler sticky flags {PE,UE,OE,ZE,DE,IE}, bit0 = IE.
REQ-006 SHALL have port irq_enable, input, 1: when 0, new interrupts are not raised.
REQ-007 SHALL have port irq_ack, input, 1: one-cycle acknowledge from the interrupt controller.
REQ-008 SHALL have port clear_cmd, input, 1: one-cycle FCLEX or error-port write from the CPU side.
REQ-009 SHALL have port exception_clear, output, 1: one-cycle clear pulse to the handler.
REQ-010 SHALL have port irq_out, output, 1: level IRQ to the interrupt controller.
REQ-011 SHALL have port cause, output, 6: latched_exceptions captured at interrupt entry.
REQ-012 SHALL have port cause_valid, output, 1: cause holds an unserviced snapshot.
REQ-013 SHALL have port stuck, output, 1: sticky flag meaning the handler failed to drop INT within DRAIN_TIMEOUT.
REQ-014 SHALL have port irq_count, output, 8: serviced-interrupt counter.
REQ-015 SHALL have port state_dbg, output, 3: encoding of the current FSM state.

Function
REQ-016 SHALL implement these FSM states and encodings: IDLE=0, PENDING=1, SERVICE=2, CLEAR=3, DRAIN=4.
REQ-017 IDLE: when int_request=1, irq_enable=1 and stuck=0, SHALL capture cause<=latched_exceptions, set cause_valid=1 and go to PENDING on the same edge.
REQ-018 PENDING: SHALL drive irq_out=1, registered, starting the cycle after entry.
REQ-019 PENDING: on irq_ack, SHALL go to SERVICE.
REQ-020 PENDING: on clear_cmd (polled software path), SHALL go to CLEAR; clear_cmd takes priority over a simultaneous irq_ack.
REQ-021 PENDING: if irq_enable falls, SHALL return to IDLE; cause and cause_valid are held.
REQ-022 SHALL keep irq_out=0 in every state other than PENDING.
REQ-023 SHALL ignore irq_ack in IDLE, SERVICE, CLEAR and DRAIN.
REQ-024 SERVICE: on clear_cmd, SHALL go to CLEAR.
REQ-025 CLEAR: SHALL hold exactly one cycle, asserting exception_clear=1 for that cycle only.
REQ-026 CLEAR: SHALL clear cause_valid, increment irq_count (modulo 256, 0xFF wraps to 0x00), load the drain counter with DRAIN_TIMEOUT-1 and go to DRAIN.
REQ-027 DRAIN: if int_request=0, SHALL go to IDLE.
REQ-028 DRAIN: otherwise, if the counter reads 0, SHALL set stuck=1 and go to IDLE; otherwise SHALL decrement the counter.
REQ-029 DRAIN: int_request is never re-sampled as a new interrupt until IDLE is reached.
REQ-030 clear_cmd seen in IDLE with stuck=1 SHALL clear stuck and issue one exception_clear pulse without incrementing irq_count.
REQ-031 clear_cmd in IDLE with stuck=0 SHALL be ignored.
REQ-032 A clear_cmd arriving during CLEAR or DRAIN SHALL be ignored.
REQ-033 cause SHALL change only on IDLE->PENDING entry; it is held otherwise, including across CLEAR.
REQ-034 Latency: int_request rising in IDLE -> irq_out=1 exactly 2 cycles later.
REQ-035 Latency: clear_cmd in SERVICE -> exception_clear=1 in the next cycle.

Reset
REQ-036 reset_n=0 SHALL immediately force state IDLE and clear all outputs: irq_out=0, exception_clear=0, cause=6'h00, cause_valid=0, stuck=0, irq_count=8'h00, state_dbg=0.
REQ-037 SHALL clear the drain counter on reset.
REQ-038 Reset asserted mid-PENDING SHALL drop irq_out without waiting for a clock edge.
REQ-039 After reset_n rises, SHALL sample int_request normally from the first clock edge.

Verification
REQ-040 SHALL test the basic path: irq_enable=1, int_request=1 with latched_exceptions=6'h01 -> irq_out=1 at +2 cycles and cause=6'h01, cause_valid=1; then irq_ack -> irq_out=0; then clear_cmd -> one exception_clear pulse; handler drops INT -> IDLE, irq_count=1, cause_valid=0.
REQ-041 SHALL test the polled path: int_request with 6'h3F, no irq_ack, clear_cmd while PENDING -> CLEAR entered directly, cause=6'h3F retained, irq_count increments.
REQ-042 SHALL test the disabled path: irq_enable=0 with int_request=1 for 10 cycles -> irq_out stays 0; raise irq_enable -> irq_out=1 two cycles later.
REQ-043 SHALL test stuck handling: int_request held 1 after the clear pulse -> stuck=1 exactly DRAIN_TIMEOUT cycles after DRAIN entry, no re-raise of irq_out; then clear_cmd -> stuck=0 plus one exception_clear pulse.
REQ-044 SHALL test counter wrap: 256 complete service sequences -> irq_count=8'h00.
REQ-045 SHALL test asynchronous reset: pulse reset_n low mid-PENDING between clock edges -> irq_out=0 immediately and all outputs at their reset values.
